xorshift32_rewind: RTL and testbench

Backward-stepping companion to the xorshift32 (13/17/5) PRNG. It holds a 32-bit generator state and, on request, walks that state back N steps by exactly inverting the forward recurrence. It sits beside the forward generator in the quantum-measurement sampling path, so a run can be replayed or an earlier random draw can be recovered without storing history. The inversion is iterative and multi-cycle, with a valid/ready request handshake and a one-cycle done pulse.

---
 rtl/xorshift32_pkg.sv | 26 ++
 rtl/xorshift32_rewind_if.sv | 23 ++
 rtl/xorshift32_unshift_stage.sv | 14 +
 rtl/xorshift32_rewind.sv | 119 +++++++++++
 tb/tb_xorshift32_rewind.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xorshift32_pkg.sv
// Shared definitions for the xorshift32 (13/17/5) generator and its rewind companion.
package xorshift32_pkg;

    localparam logic [31:0] XS_SEED = 32'h1a2b3c4d;

    localparam int unsigned XS_A = 13;
    localparam int unsigned XS_B = 17;
    localparam int unsigned XS_C = 5;

    typedef enum logic [1:0] {
        IDLE,
        UNDO5,
        UNDO17,
        UNDO13
    } xs_fsm_t;

    // One forward step of the generator.
    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << XS_A);
        t = t ^ (t >> XS_B);
        t = t ^ (t << XS_C);
        return t;
    endfunction

endpackage

// File: rtl/xorshift32_rewind_if.sv
// Request/status bundle between a requester and the xorshift32 rewind engine.
interface xorshift32_rewind_if #(
    parameter int unsigned CNT_W = 16
);
    logic             load;
    logic [31:0]      load_state;
    logic             req_valid;
    logic [CNT_W-1:0] req_steps;
    logic             req_ready;
    logic             busy;
    logic             done;
    logic [31:0]      state;

    modport master (
        output load, load_state, req_valid, req_steps,
        input  req_ready, busy, done, state
    );

    modport slave (
        input  load, load_state, req_valid, req_steps,
        output req_ready, busy, done, state
    );
endinterface

// File: rtl/xorshift32_unshift_stage.sv
// Single xor-shift term y ^ (y >> amt) or y ^ (y << amt); zero fill, 32-bit truncation.
module xorshift32_unshift_stage (
    input  logic [31:0] y_in,
    input  logic        dir,
    input  logic [4:0]  amt,
    output logic [31:0] y_out
);

    // dir=1 selects a right shift, dir=0 a left shift.
    always_comb begin
        y_out = y_in ^ (dir ? (y_in >> amt) : (y_in << amt));
    end

endmodule

// File: rtl/xorshift32_rewind.sv
// Walks the xorshift32 state back N steps, 6 cycles per step (undo <<5, >>17, <<13).
module xorshift32_rewind
    import xorshift32_pkg::*;
#(
    parameter logic [31:0] SEED  = XS_SEED,
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 reset,
    xorshift32_rewind_if.slave  bus
);

    xs_fsm_t          fsm;
    xs_fsm_t          fsm_next;
    logic [1:0]       sub;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      state_q;
    logic             done_q;

    logic             accept;
    logic             last_sub;
    logic             step_dir;
    logic [4:0]       step_amt;
    logic [31:0]      step_out;

    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.req_ready = (fsm == IDLE) && !bus.load;
    assign bus.busy      = (fsm != IDLE);
    assign bus.done      = done_q;
    assign bus.state     = state_q;

    xorshift32_unshift_stage u_stage (
        .y_in  (state_q),
        .dir   (step_dir),
        .amt   (step_amt),
        .y_out (step_out)
    );

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Phase sequencing: UNDO5 x3, UNDO17 x1, UNDO13 x2, repeated per step.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:   if (accept && (bus.req_steps != '0)) fsm_next = UNDO5;
            UNDO5:  if (last_sub) fsm_next = UNDO17;
            UNDO17: fsm_next = UNDO13;
            UNDO13: if (last_sub) fsm_next = (remaining == CNT_W'(1)) ? IDLE : UNDO5;
            default: fsm_next = IDLE;
        endcase
    end

    // Shift selection per phase and sub-iteration; amounts double to invert y^=y<<s.
    always_comb begin
        step_dir = 1'b0;
        step_amt = '0;
        last_sub = 1'b0;
        case (fsm)
            UNDO5: begin
                case (sub)
                    2'd0:    step_amt = 5'(XS_C);
                    2'd1:    step_amt = 5'(2 * XS_C);
                    default: step_amt = 5'(4 * XS_C);
                endcase
                last_sub = (sub == 2'd2);
            end
            UNDO17: begin
                step_dir = 1'b1;
                step_amt = 5'(XS_B);
                last_sub = 1'b1;
            end
            UNDO13: begin
                step_amt = (sub == 2'd0) ? 5'(XS_A) : 5'(2 * XS_A);
                last_sub = (sub == 2'd1);
            end
            default: ;
        endcase
    end

    // State register and counters: load/capture while idle, one xor-shift per busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEED;
            sub       <= '0;
            remaining <= '0;
        end else if (fsm == IDLE) begin
            sub <= '0;
            if (bus.load) begin
                state_q <= bus.load_state;
            end else if (accept) begin
                remaining <= bus.req_steps;
            end
        end else begin
            state_q <= step_out;
            sub     <= last_sub ? 2'd0 : sub + 2'd1;
            if ((fsm == UNDO13) && last_sub) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    // Completion pulse: zero-step acceptance or the final UNDO13 sub-iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (accept && (bus.req_steps == '0)) ||
                      ((fsm == UNDO13) && last_sub && (remaining == CNT_W'(1)));
        end
    end

endmodule

// File: tb/tb_xorshift32_rewind.sv
// Bench for xorshift32_rewind: history-based reference model plus directed and random rewinds.
module tb_xorshift32_rewind;
    import xorshift32_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam int          HMAX  = 1000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    xorshift32_rewind_if #(.CNT_W(CNT_W)) bus ();

    xorshift32_rewind #(.SEED(XS_SEED), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // hist[k] = k forward steps from hist[0]; rewinding r steps from hist[k] must give hist[k-r].
    logic [31:0] hist [0:HMAX];
    int          ld_idx = 0;

    int          m_cycles = 0;
    int          m_idx    = -1;
    bit          m_known  = 1'b1;
    bit          m_done   = 1'b0;
    logic [31:0] m_state  = XS_SEED;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_hist(input logic [31:0] base, input int len);
        hist[0] = base;
        for (int i = 1; i <= len; i++) hist[i] = xs_step(hist[i-1]);
    endfunction

    // Reference model: a rewind is a 6N-cycle busy window ending on the earlier history entry.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_state  = XS_SEED;
                m_cycles = 0;
                m_idx    = -1;
                m_known  = 1'b1;
                m_done   = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_cycles > 0) begin
                    m_cycles--;
                    if (m_cycles == 0) begin
                        m_done = 1'b1;
                        if (m_known) m_state = hist[m_idx];
                    end
                end else if (bus.load) begin
                    m_idx   = ld_idx;
                    m_state = hist[ld_idx];
                    m_known = 1'b1;
                end else if (bus.req_valid) begin
                    if (bus.req_steps == '0) begin
                        m_done = 1'b1;
                    end else begin
                        m_cycles = 6 * int'(bus.req_steps);
                        if (m_known && m_idx >= int'(bus.req_steps)) m_idx -= int'(bus.req_steps);
                        else m_known = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(m_cycles > 0));
        check("done", 32'(bus.done), 32'(m_done));
        check("req_ready", 32'(bus.req_ready), 32'((m_cycles == 0) && !bus.load));
        if (m_cycles == 0 && m_known) check("state_idle", bus.state, m_state);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int idx);
        bus.load       = 1'b1;
        bus.load_state = hist[idx];
        ld_idx         = idx;
        tick();
        bus.load = 1'b0;
    endtask

    // Presents a request and returns #1 after the acceptance edge E0; req_valid is left asserted.
    task automatic accept_req(input int n);
        int guard;
        bus.req_valid = 1'b1;
        bus.req_steps = CNT_W'(n);
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        check("req_accept", 32'(bus.req_ready), 32'h1);
        tick();
    endtask

    // Counts edges after E0 until done is seen; optionally probes the state mid-rewind.
    task automatic wait_done(input int n, input int probe_at, input logic [31:0] probe_val,
                             input bit watch_zero, output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.done && lat < 6 * n + 20) begin
            if (lat == probe_at) check("probe_state", bus.state, probe_val);
            if (watch_zero) check("zero_fixed", bus.state, 32'h0);
            lat++;
            @(negedge clk);
        end
        check("done_seen", 32'(bus.done), 32'h1);
        check("latency", 32'(lat), 32'(6 * n));
    endtask

    initial begin
        int lat;
        int n;
        int k;
        bus.load       = 1'b0;
        bus.load_state = '0;
        bus.req_valid  = 1'b0;
        bus.req_steps  = '0;

        check("model_step_of_1", xs_step(32'h1), 32'h00042021);

        repeat (3) tick();
        check("reset_state", bus.state, 32'h1a2b3c4d);
        reset = 1'b0;
        tick();

        // Zero-step request.
        accept_req(0);
        bus.req_valid = 1'b0;
        wait_done(0, -1, '0, 1'b0, lat);
        check("n0_state", bus.state, 32'h1a2b3c4d);

        // Single step from the image of 1, with a probe after the UNDO5 phase.
        build_hist(32'h1, 1);
        do_load(1);
        check("loaded_42021", bus.state, 32'h00042021);
        accept_req(1);
        bus.req_valid = 1'b0;
        wait_done(1, 3, 32'h00002001, 1'b0, lat);
        check("n1_state", bus.state, 32'h00000001);

        // 1000 steps back to the seed.
        build_hist(XS_SEED, 1000);
        do_load(1000);
        accept_req(1000);
        bus.req_valid = 1'b0;
        wait_done(1000, -1, '0, 1'b0, lat);
        check("n1000_state", bus.state, 32'h1a2b3c4d);

        // Zero is a fixed point but still costs the full cycle count.
        build_hist(32'h0, 5);
        do_load(5);
        accept_req(5);
        bus.req_valid = 1'b0;
        wait_done(5, -1, '0, 1'b1, lat);
        check("zero_state", bus.state, 32'h0);

        // Random partial rewinds.
        for (int t = 0; t < 10; t++) begin
            n = int'($urandom_range(1, 12));
            k = int'($urandom_range(1, n));
            build_hist($urandom, n);
            do_load(n);
            repeat ($urandom_range(0, 3)) tick();
            accept_req(k);
            bus.req_valid = 1'b0;
            wait_done(k, -1, '0, 1'b0, lat);
            check("rand_state", bus.state, hist[n-k]);
        end

        // Load and request while busy are ignored, then reset abandons the rewind.
        build_hist($urandom, 10);
        do_load(10);
        accept_req(10);
        bus.req_valid = 1'b0;
        repeat (16) tick();
        bus.load       = 1'b1;
        bus.load_state = $urandom;
        bus.req_valid  = 1'b1;
        bus.req_steps  = CNT_W'(1);
        tick();
        bus.load      = 1'b0;
        bus.req_valid = 1'b0;
        check("busy_after_ignored", 32'(bus.busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_state", bus.state, 32'h1a2b3c4d);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'h1);
        repeat (70) tick();

        // Back-to-back: 2 steps, then 3 steps accepted in the done cycle.
        build_hist($urandom, 5);
        do_load(5);
        accept_req(2);
        bus.req_steps = CNT_W'(3);
        wait_done(2, -1, '0, 1'b0, lat);
        tick();
        bus.req_valid = 1'b0;
        wait_done(3, -1, '0, 1'b0, lat);
        check("b2b_state", bus.state, hist[0]);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
